gaussian_3x3_stream: RTL and testbench

GAUSSIAN_3X3_STREAM -- requirements
Module: gaussian_3x3_stream

---
 rtl/gaussian_pkg.sv | 32 +++
 rtl/gaussian_line_buffer.sv | 35 +++
 rtl/gaussian_3x3_stream.sv | 186 ++++++++++++++++++
 tb/tb_gaussian_3x3_stream.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gaussian_pkg
// Purpose  : Shared 3x3 Gaussian kernel weights and fixed-point scaling.
// Revision : 1.0 - initial release
// ============================================================================
package gaussian_pkg;

    localparam int c_KERNEL_DIM = 3;

    // Kernel [1 2 1; 2 4 2; 1 2 1]; weights sum to 16 = 2**c_SHIFT.
    localparam int c_W_CORNER = 1;
    localparam int c_W_EDGE   = 2;
    localparam int c_W_CENTER = 4;

    localparam int c_SHIFT      = 4;
    localparam int c_GUARD_BITS = 4;

    function automatic int kernel_weight(input int row, input int col);
        int w;
        if (row == 1 && col == 1) begin
            w = c_W_CENTER;
        end else if (row == 1 || col == 1) begin
            w = c_W_EDGE;
        end else begin
            w = c_W_CORNER;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gaussian_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : gaussian_line_buffer
// Purpose  : One image row of delay; simple dual-port RAM with registered read.
// Revision : 1.0 - initial release
// ============================================================================
module gaussian_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 48,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // The caller never reads the address it writes in the same cycle, so no
    // read-during-write behaviour is relied upon.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[rd_addr];
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/gaussian_3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : gaussian_3x3_stream
// Purpose  : Streaming "valid" 3x3 Gaussian blur over raster frames with
//            ready/valid handshakes and a single output register.
// Revision : 1.0 - initial release
// ============================================================================
module gaussian_3x3_stream
    import gaussian_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = 16,
    parameter int IN_ROWS          = 48,
    parameter int IN_COLS          = 48,
    parameter int IMG_ROW_BITWIDTH = 10,
    parameter int IMG_COL_BITWIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
    input  logic                       pixel_in_TVALID,
    output logic                       pixel_in_TREADY,
    output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
    output logic                       pixel_out_TVALID,
    input  logic                       pixel_out_TREADY,
    output logic                       pixel_out_TLAST
);

    localparam int c_ACC_W  = PIXEL_BIT_WIDTH + c_GUARD_BITS;
    localparam int c_LB_AW  = $clog2(IN_COLS);
    localparam logic [IMG_COL_BITWIDTH-1:0] c_LAST_COL = IMG_COL_BITWIDTH'(IN_COLS - 1);
    localparam logic [IMG_ROW_BITWIDTH-1:0] c_LAST_ROW = IMG_ROW_BITWIDTH'(IN_ROWS - 1);
    localparam logic [IMG_COL_BITWIDTH-1:0] c_FIRST_OUT_COL = IMG_COL_BITWIDTH'(2);
    localparam logic [IMG_ROW_BITWIDTH-1:0] c_FIRST_OUT_ROW = IMG_ROW_BITWIDTH'(2);

    logic [IMG_COL_BITWIDTH-1:0] r_col;
    logic [IMG_ROW_BITWIDTH-1:0] r_row;
    logic [IMG_COL_BITWIDTH-1:0] w_col_next;
    logic [IMG_ROW_BITWIDTH-1:0] w_row_next;
    logic [IMG_COL_BITWIDTH-1:0] w_rd_col;
    logic                        w_col_wrap;
    logic                        w_row_wrap;
    logic                        w_in_ready;
    logic                        w_in_fire;
    logic                        w_win_full;

    logic [PIXEL_BIT_WIDTH-1:0]  w_lb1_q;
    logic [PIXEL_BIT_WIDTH-1:0]  w_lb2_q;
    logic [PIXEL_BIT_WIDTH-1:0]  w_col_cur [c_KERNEL_DIM];
    logic [PIXEL_BIT_WIDTH-1:0]  r_col_m1  [c_KERNEL_DIM];
    logic [PIXEL_BIT_WIDTH-1:0]  r_col_m2  [c_KERNEL_DIM];
    logic [PIXEL_BIT_WIDTH-1:0]  w_win     [c_KERNEL_DIM][c_KERNEL_DIM];

    logic signed [c_ACC_W-1:0]   w_prod    [c_KERNEL_DIM][c_KERNEL_DIM];
    logic signed [c_ACC_W-1:0]   w_acc;
    logic [PIXEL_BIT_WIDTH-1:0]  w_filt;
    logic                        w_unused;

    logic [PIXEL_BIT_WIDTH-1:0]  r_out_data;
    logic                        r_out_valid;
    logic                        r_out_last;

    // ------------------------------------------------------------------
    // Handshake and raster position
    // ------------------------------------------------------------------
    assign w_in_ready = !r_out_valid || pixel_out_TREADY;
    assign w_in_fire  = pixel_in_TVALID && w_in_ready && !reset;

    assign w_col_wrap = (r_col == c_LAST_COL);
    assign w_row_wrap = (r_row == c_LAST_ROW);
    assign w_col_next = w_col_wrap ? '0 : r_col + IMG_COL_BITWIDTH'(1);
    assign w_row_next = !w_col_wrap ? r_row :
                        (w_row_wrap ? '0 : r_row + IMG_ROW_BITWIDTH'(1));
    assign w_win_full = (r_row >= c_FIRST_OUT_ROW) && (r_col >= c_FIRST_OUT_COL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_fire) begin
            r_col <= w_col_next;
            r_row <= w_row_next;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: read address runs one pixel ahead so the registered
    // read data for the column about to arrive is ready at its handshake.
    // ------------------------------------------------------------------
    assign w_rd_col = reset ? '0 : (w_in_fire ? w_col_next : r_col);

    gaussian_line_buffer #(
        .DATA_WIDTH (PIXEL_BIT_WIDTH),
        .DEPTH      (IN_COLS),
        .ADDR_WIDTH (c_LB_AW)
    ) u_line_buf_1 (
        .clk     (clk),
        .wr_en   (w_in_fire),
        .wr_addr (r_col[c_LB_AW-1:0]),
        .wr_data (pixel_in_TDATA),
        .rd_addr (w_rd_col[c_LB_AW-1:0]),
        .rd_data (w_lb1_q)
    );

    gaussian_line_buffer #(
        .DATA_WIDTH (PIXEL_BIT_WIDTH),
        .DEPTH      (IN_COLS),
        .ADDR_WIDTH (c_LB_AW)
    ) u_line_buf_2 (
        .clk     (clk),
        .wr_en   (w_in_fire),
        .wr_addr (r_col[c_LB_AW-1:0]),
        .wr_data (w_lb1_q),
        .rd_addr (w_rd_col[c_LB_AW-1:0]),
        .rd_data (w_lb2_q)
    );

    // Window column index 0 is the oldest (c-2); row index 0 is the top (r-2).
    assign w_col_cur[0] = w_lb2_q;
    assign w_col_cur[1] = w_lb1_q;
    assign w_col_cur[2] = pixel_in_TDATA;

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            for (int i = 0; i < c_KERNEL_DIM; i++) begin
                r_col_m2[i] <= r_col_m1[i];
                r_col_m1[i] <= w_col_cur[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Weighted sum over the 3x3 window
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_KERNEL_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < c_KERNEL_DIM; gj++) begin : g_col
            if (gj == 0) begin : g_tap_m2
                assign w_win[gi][gj] = r_col_m2[gi];
            end else if (gj == 1) begin : g_tap_m1
                assign w_win[gi][gj] = r_col_m1[gi];
            end else begin : g_tap_cur
                assign w_win[gi][gj] = w_col_cur[gi];
            end
            assign w_prod[gi][gj] = c_ACC_W'($signed(w_win[gi][gj]))
                                  * $signed(c_ACC_W'(kernel_weight(gi, gj)));
        end
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < c_KERNEL_DIM; i++) begin
            for (int j = 0; j < c_KERNEL_DIM; j++) begin
                w_acc = w_acc + w_prod[i][j];
            end
        end
    end

    // Taking the bits above the shift is the floor arithmetic shift; the guard
    // bits guarantee the result already fits the pixel width.
    assign w_filt   = w_acc[c_SHIFT +: PIXEL_BIT_WIDTH];
    assign w_unused = ^{w_acc[c_SHIFT-1:0], w_rd_col};

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_in_fire && w_win_full) begin
            r_out_data  <= w_filt;
            r_out_valid <= 1'b1;
            r_out_last  <= w_row_wrap && w_col_wrap;
        end else if (pixel_out_TREADY) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign pixel_in_TREADY  = w_in_ready;
    assign pixel_out_TDATA  = r_out_data;
    assign pixel_out_TVALID = r_out_valid;
    assign pixel_out_TLAST  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_gaussian_3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_gaussian_3x3_stream
// Purpose  : Directed self-checking bench for gaussian_3x3_stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gaussian_3x3_stream;

    localparam int W     = 16;
    localparam int R     = 48;
    localparam int C     = 48;
    localparam int OC    = C - 2;
    localparam int N_IN  = R * C;
    localparam int N_OUT = (R - 2) * (C - 2);

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pixel_in_TDATA;
    logic         pixel_in_TVALID;
    logic         pixel_in_TREADY;
    logic [W-1:0] pixel_out_TDATA;
    logic         pixel_out_TVALID;
    logic         pixel_out_TREADY;
    logic         pixel_out_TLAST;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] stim [0:3*N_IN-1];
    logic [W-1:0] got_data [$];
    logic         got_last [$];
    int           stall_seen;
    int           stall_bad;
    int           extra;

    gaussian_3x3_stream #(
        .PIXEL_BIT_WIDTH  (W),
        .IN_ROWS          (R),
        .IN_COLS          (C),
        .IMG_ROW_BITWIDTH (10),
        .IMG_COL_BITWIDTH (10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pixel_in_TDATA   (pixel_in_TDATA),
        .pixel_in_TVALID  (pixel_in_TVALID),
        .pixel_in_TREADY  (pixel_in_TREADY),
        .pixel_out_TDATA  (pixel_out_TDATA),
        .pixel_out_TVALID (pixel_out_TVALID),
        .pixel_out_TREADY (pixel_out_TREADY),
        .pixel_out_TLAST  (pixel_out_TLAST)
    );

    always #5 clk = ~clk;

    // Direct 2-D convolution of frame starting at stim[base].
    function automatic logic [W-1:0] ref_px(input int base, input int i, input int j);
        int s = 0;
        for (int di = 0; di < 3; di++) begin
            for (int dj = 0; dj < 3; dj++) begin
                s += ((di == 1) ? 2 : 1) * ((dj == 1) ? 2 : 1)
                     * int'($signed(stim[base + (i + di) * C + (j + dj)]));
            end
        end
        return W'(s >>> 4);
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        pixel_in_TVALID  = 1'b0;
        pixel_in_TDATA   = '0;
        pixel_out_TREADY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drive(input int n, input bit rv, input int budget);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < budget) begin
            pixel_in_TVALID = rv ? ($urandom_range(0, 3) != 0) : 1'b1;
            pixel_in_TDATA  = stim[idx];
            @(negedge clk);
            if (pixel_in_TVALID && pixel_in_TREADY === 1'b1) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        pixel_in_TVALID = 1'b0;
    endtask

    task automatic collect(input int n, input bit rr, input int st_at, input int st_len,
                           input int budget);
        int           cyc  = 0;
        bit           stalling;
        bit           have = 1'b0;
        logic [W-1:0] held = '0;
        got_data.delete();
        got_last.delete();
        stall_seen = 0;
        stall_bad  = 0;
        while (got_data.size() < n && cyc < budget) begin
            stalling = (cyc >= st_at) && (cyc < st_at + st_len);
            if (stalling)  pixel_out_TREADY = 1'b0;
            else if (rr)   pixel_out_TREADY = ($urandom_range(0, 2) != 0);
            else           pixel_out_TREADY = 1'b1;
            @(negedge clk);
            if (stalling && pixel_out_TVALID === 1'b1) begin
                stall_seen++;
                if (!have) begin
                    held = pixel_out_TDATA;
                    have = 1'b1;
                end else if (pixel_out_TDATA !== held || pixel_in_TREADY !== 1'b0) begin
                    stall_bad++;
                end
            end
            if (pixel_out_TVALID === 1'b1 && pixel_out_TREADY) begin
                got_data.push_back(pixel_out_TDATA);
                got_last.push_back(pixel_out_TLAST);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_stream(input int n_in, input int n_out, input bit rv, input bit rr,
                              input int st_at, input int st_len);
        fork
            drive(n_in, rv, 25000 * (n_in / N_IN + 1));
            collect(n_out, rr, st_at, st_len, 25000 * (n_out / N_OUT + 1));
        join
        pixel_out_TREADY = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (pixel_out_TVALID === 1'b1) extra++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pixel_in_TVALID  = 1'b0;
        pixel_in_TDATA   = '0;
        pixel_out_TREADY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pixel_out_TVALID !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b expected=0", pixel_out_TVALID); end
        checks++; if (pixel_out_TLAST !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b expected=0", pixel_out_TLAST); end
        checks++; if (pixel_out_TDATA !== '0) begin failures++; $display("FAIL reset_tdata got=%h expected=0", pixel_out_TDATA); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (pixel_in_TREADY !== 1'b1) begin failures++; $display("FAIL reset_tready got=%b expected=1", pixel_in_TREADY); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        int bad = 0;
        apply_reset();
        pixel_in_TVALID = 1'b1;
        pixel_in_TDATA  = 16'd7;
        // Continuous acceptance: edge k takes pixel k; (2,2) is index 2*C+2.
        for (int k = 0; k <= 2 * C + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (pixel_out_TVALID !== (k >= 2 * C + 2)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL latency_tvalid wrong_cycles=%0d expected=0", bad); end
        checks++; if (pixel_out_TDATA !== 16'd7) begin failures++; $display("FAIL latency_first_data got=%0d expected=7", pixel_out_TDATA); end
        @(posedge clk);
        #1;
        pixel_in_TVALID = 1'b0;
    endtask

    task automatic test_constant(input string name, input logic [W-1:0] v);
        int bad = 0, lbad = 0, first = -1;
        for (int k = 0; k < N_IN; k++) stim[k] = v;
        apply_reset();
        run_stream(N_IN, N_OUT, 1'b0, 1'b0, -1, 0);
        checks++; if (got_data.size() != N_OUT) begin failures++; $display("FAIL %s_count got=%0d expected=%0d", name, got_data.size(), N_OUT); end
        for (int k = 0; k < got_data.size(); k++) begin
            if (got_data[k] !== v) begin bad++; if (first < 0) first = k; end
            if (got_last[k] !== (k == N_OUT - 1)) lbad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL %s_data first_index=%0d got=%h expected=%h mismatches=%0d", name, first, got_data[first], v, bad); end
        checks++; if (lbad != 0) begin failures++; $display("FAIL %s_tlast wrong=%0d expected=0", name, lbad); end
        checks++; if (extra != 0) begin failures++; $display("FAIL %s_extra got=%0d expected=0", name, extra); end
    endtask

    task automatic test_impulse();
        int bad = 0, first = -1, di, dj;
        logic [W-1:0] exp_v, first_exp;
        for (int k = 0; k < N_IN; k++) stim[k] = '0;
        stim[10 * C + 10] = 16'd16;
        apply_reset();
        run_stream(N_IN, N_OUT, 1'b0, 1'b0, -1, 0);
        checks++; if (got_data.size() != N_OUT) begin failures++; $display("FAIL impulse_count got=%0d expected=%0d", got_data.size(), N_OUT); end
        first_exp = '0;
        for (int k = 0; k < got_data.size(); k++) begin
            di = k / OC - 9;
            dj = k % OC - 9;
            if (di >= -1 && di <= 1 && dj >= -1 && dj <= 1)
                exp_v = W'(((di == 0) ? 2 : 1) * ((dj == 0) ? 2 : 1));
            else
                exp_v = '0;
            if (got_data[k] !== exp_v) begin bad++; if (first < 0) begin first = k; first_exp = exp_v; end end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL impulse_data first_index=%0d got=%0d expected=%0d mismatches=%0d", first, got_data[first], first_exp, bad); end
    endtask

    task automatic test_ramp_backpressure(input string name, input int st_at, input int st_len);
        int bad = 0, lbad = 0, first = -1;
        for (int k = 0; k < N_IN; k++) stim[k] = W'(k % C);
        apply_reset();
        pixel_in_TVALID = 1'b1;
        run_stream(N_IN, N_OUT, 1'b0, 1'b0, st_at, st_len);
        checks++; if (got_data.size() != N_OUT) begin failures++; $display("FAIL %s_count got=%0d expected=%0d", name, got_data.size(), N_OUT); end
        for (int k = 0; k < got_data.size(); k++) begin
            if (got_data[k] !== W'(k % OC + 1)) begin bad++; if (first < 0) first = k; end
            if (got_last[k] !== (k == N_OUT - 1)) lbad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL %s_data first_index=%0d got=%0d expected=%0d mismatches=%0d", name, first, got_data[first], first % OC + 1, bad); end
        checks++; if (lbad != 0) begin failures++; $display("FAIL %s_tlast wrong=%0d expected=0", name, lbad); end
        checks++; if (extra != 0) begin failures++; $display("FAIL %s_extra got=%0d expected=0", name, extra); end
        if (st_len > 0) begin
            checks++; if (stall_seen < st_len - 3) begin failures++; $display("FAIL %s_stall_valid cycles=%0d expected>=%0d", name, stall_seen, st_len - 3); end
            checks++; if (stall_bad != 0) begin failures++; $display("FAIL %s_stall_hold violations=%0d expected=0", name, stall_bad); end
        end
    endtask

    task automatic check_model(input string name, input int nframes);
        int bad = 0, lbad = 0, first = -1, o;
        logic [W-1:0] exp_v, first_exp;
        first_exp = '0;
        checks++; if (got_data.size() != nframes * N_OUT) begin failures++; $display("FAIL %s_count got=%0d expected=%0d", name, got_data.size(), nframes * N_OUT); end
        for (int k = 0; k < got_data.size(); k++) begin
            o = k % N_OUT;
            exp_v = ref_px((k / N_OUT) * N_IN, o / OC, o % OC);
            if (got_data[k] !== exp_v) begin bad++; if (first < 0) begin first = k; first_exp = exp_v; end end
            if (got_last[k] !== (o == N_OUT - 1)) lbad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL %s_data first_index=%0d got=%h expected=%h mismatches=%0d", name, first, got_data[first], first_exp, bad); end
        checks++; if (lbad != 0) begin failures++; $display("FAIL %s_tlast wrong=%0d expected=0", name, lbad); end
        checks++; if (extra != 0) begin failures++; $display("FAIL %s_extra got=%0d expected=0", name, extra); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3 * N_IN; k++) stim[k] = W'($urandom);
        apply_reset();
        run_stream(3 * N_IN, 3 * N_OUT, 1'b1, 1'b1, -1, 0);
        check_model("b2b", 3);
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < N_IN; k++) stim[k] = W'($urandom);
        apply_reset();
        drive(1000, 1'b0, 5000);
        reset = 1'b1;
        pixel_out_TREADY = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (pixel_out_TVALID !== 1'b0 || pixel_out_TLAST !== 1'b0 || pixel_out_TDATA !== '0) begin
            failures++; $display("FAIL midreset_state got=%b/%b/%h expected=0/0/0", pixel_out_TVALID, pixel_out_TLAST, pixel_out_TDATA);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (pixel_in_TREADY !== 1'b1) begin failures++; $display("FAIL midreset_tready got=%b expected=1", pixel_in_TREADY); end
        @(posedge clk);
        #1;
        for (int k = 0; k < N_IN; k++) stim[k] = W'($urandom);
        run_stream(N_IN, N_OUT, 1'b1, 1'b1, -1, 0);
        check_model("midreset", 1);
    endtask

    initial begin
        reset            = 1'b1;
        pixel_in_TVALID  = 1'b0;
        pixel_in_TDATA   = '0;
        pixel_out_TREADY = 1'b0;
        test_reset();
        test_latency();
        test_constant("const100", 16'd100);
        test_impulse();
        test_constant("const_neg1", 16'hFFFF);
        test_ramp_backpressure("ramp", -1, 0);
        test_ramp_backpressure("stall", 500, 200);
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
